// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
//
// Round-robin arbiter that merges N upstream valid/ready masters onto one
// downstream valid/ready channel. The downstream side is a 2-entry skid
// stage (output entry + skid entry), so s_valid/s_data/s_id are registered
// and the upstream ready is derived from register state only; there is no
// combinational path from s_ready to m_ready.
//
// Optional feature (compile-time macro ARB_PKT_LOCK_EN):
//   When defined, a beat accepted with m_last[i]=0 locks the grant to
//   requester i until a beat from i with m_last=1 is accepted. When not
//   defined, m_last is ignored and every beat is arbitrated independently.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   m_valid  in   [N]      per-requester valid
//   m_data   in   [N*DW]   requester i at [i*DW +: DW]
//   m_last   in   [N]      end-of-packet flag (lock feature only)
//   m_ready  out  [N]      per-requester ready, one-hot or zero
//   s_valid  out           downstream valid (registered)
//   s_data   out  [DW]     downstream data (registered)
//   s_id     out  [IDW]    requester index of s_data (registered)
//   s_ready  in            downstream ready

module handshake_rr_arbiter #(
  parameter int N   = 4,
  parameter int DW  = 32,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    m_valid,
  input  logic [N*DW-1:0] m_data,
  input  logic [N-1:0]    m_last,
  output logic [N-1:0]    m_ready,
  output logic            s_valid,
  output logic [DW-1:0]   s_data,
  output logic [IDW-1:0]  s_id,
  input  logic            s_ready
);

  if (N < 2 || N > 16 || N > (1 << IDW)) begin : g_bad_param
    $error("handshake_rr_arbiter: need 2 <= N <= 16 and N <= 2**IDW");
  end

  logic [IDW-1:0] last_grant;

  logic           skid_valid;
  logic [DW-1:0]  skid_data;
  logic [IDW-1:0] skid_id;

  logic           hit;
  logic [IDW-1:0] sel;
  logic [N-1:0]   grant;
  logic           in_ready;
  logic           accept;
  logic [DW-1:0]  acc_data;
  logic           drain;

`ifdef ARB_PKT_LOCK_EN
  logic           lock;
  logic [IDW-1:0] lock_id;
`else
  logic           unused_m_last;
  assign unused_m_last = ^m_last;
`endif

  // Round-robin search without modulo arithmetic: first look above the
  // pointer, then wrap and look from 0 up to and including the pointer.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && m_valid[i] && (i > int'(last_grant))) begin
        hit = 1'b1;
        sel = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!hit && m_valid[i] && (i <= int'(last_grant))) begin
        hit = 1'b1;
        sel = IDW'(i);
      end
    end
`ifdef ARB_PKT_LOCK_EN
    // A locked packet owns the channel even while its master idles.
    if (lock) begin
      hit = m_valid[lock_id];
      sel = lock_id;
    end
`endif
  end

  always_comb begin
    grant = '0;
    if (hit) grant = N'(1) << sel;
  end

  // The skid entry only fills while the output entry is stalled, so an
  // empty skid always leaves room for one more beat.
  assign in_ready = ~skid_valid & ~rst;
  assign m_ready  = grant & {N{in_ready}};
  assign accept   = hit & in_ready;
  assign drain    = s_valid & s_ready;

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IDW'(i)) acc_data = m_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_valid    <= 1'b0;
      s_data     <= '0;
      s_id       <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_id    <= '0;
      last_grant <= IDW'(N - 1);
    end else begin
      if (accept) last_grant <= sel;

      if (!s_valid || drain) begin
        // Output entry is free this edge. A full skid has priority; no
        // accept can happen in that cycle because in_ready is low.
        if (skid_valid) begin
          s_valid    <= 1'b1;
          s_data     <= skid_data;
          s_id       <= skid_id;
          skid_valid <= 1'b0;
        end else if (accept) begin
          s_valid <= 1'b1;
          s_data  <= acc_data;
          s_id    <= sel;
        end else if (drain) begin
          s_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= acc_data;
        skid_id    <= sel;
      end
    end
  end

`ifdef ARB_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock    <= 1'b0;
      lock_id <= '0;
    end else if (accept) begin
      lock    <= ~m_last[sel];
      lock_id <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
module tb_handshake_rr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_valid = '0;
  logic [N*DW-1:0] m_data = '0;
  logic [N-1:0]    m_last = '0;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [DW-1:0]   s_data;
  logic [IDW-1:0]  s_id;
  logic            s_ready = 1'b0;

  handshake_rr_arbiter #(.N(N), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .s_valid(s_valid), .s_data(s_data), .s_id(s_id), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of stored beats (at most 2), the index
  // of the last winner, and the packet lock.
  typedef struct {
    logic [DW-1:0] data;
    int            id;
  } beat_t;

  beat_t q[$];
  int    ptr;
  bit    lk;
  int    lk_id;
  int    vectors = 0;
  int    miscompares = 0;
  int    seq[N];

  function automatic int exp_grant();
    if (rst || q.size() >= 2) return -1;
`ifdef ARB_PKT_LOCK_EN
    if (lk) return m_valid[lk_id] ? lk_id : -1;
`endif
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (m_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    m_data[i*DW +: DW] = v;
  endtask

  // Entered 1 time unit after a rising edge with inputs already driven.
  // Checks outputs, advances the model across the next edge, returns the
  // requester the model expected to be accepted (-1 for none).
  task automatic cycle(output int g);
    logic [N-1:0] er;
    #3;
    g  = exp_grant();
    er = (g >= 0) ? (N'(1) << g) : '0;
    chk("m_ready", 64'(m_ready), 64'(er));
    chk("s_valid", 64'(s_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("s_data", 64'(s_data), 64'(q[0].data));
      chk("s_id", 64'(s_id), 64'(q[0].id));
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      ptr = N - 1;
      lk  = 1'b0;
    end else begin
      if (q.size() > 0 && s_ready) void'(q.pop_front());
      if (g >= 0) begin
        beat_t b;
        b.data = m_data[g*DW +: DW];
        b.id   = g;
        q.push_back(b);
        ptr   = g;
        lk    = ~m_last[g];
        lk_id = g;
      end
    end
    #1;
  endtask

  initial begin
    int g;
    int cnt;
    ptr = N - 1; lk = 1'b0; lk_id = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;

    // Reset held with every requester valid.
    rst = 1'b1; m_valid = '1; s_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 32'hDEAD_0000 + i);
    @(posedge clk); #1;
    repeat (3) begin
      chk("rst_s_id", 64'(s_id), 64'd0);
      cycle(g);
    end

    // First grant after release must be requester 0.
    rst = 1'b0;
    cycle(g);
    chk("first_grant", 64'(g), 64'd0);
    m_valid = '0;
    repeat (2) cycle(g);

    // Single requester 2 streams 0xA0..0xA7.
    cnt = 0;
    m_valid = 4'b0100;
    for (int t = 0; t < 20 && cnt < 8; t++) begin
      set_data(2, 32'hA0 + cnt);
      cycle(g);
      if (g == 2) cnt++;
    end
    chk("stream_cnt", 64'(cnt), 64'd8);
    m_valid = '0;
    repeat (2) cycle(g);

    // All requesters valid, unique streams.
    m_valid = '1;
    repeat (16) begin
      for (int i = 0; i < N; i++) set_data(i, {8'(i), 24'(seq[i])});
      cycle(g);
      if (g >= 0) seq[g]++;
    end
    m_valid = '0;
    repeat (2) cycle(g);

    // Backpressure on a continuous requester 1.
    m_valid = 4'b0010; s_ready = 1'b0; cnt = 0;
    repeat (4) begin
      set_data(1, 32'hB100 + cnt);
      cycle(g);
      if (g == 1) cnt++;
    end
    chk("bp_stored", 64'(cnt), 64'd2);
    s_ready = 1'b1;
    repeat (8) begin
      set_data(1, 32'hB100 + cnt);
      cycle(g);
      if (g == 1) cnt++;
    end
    m_valid = '0;
    repeat (2) cycle(g);

    // Requester 3 packet with requester 0 waiting and an idle mid-packet.
    m_valid = 4'b1001; cnt = 0;
    set_data(0, 32'hC000_0000);
    for (int t = 0; t < 10; t++) begin
      m_valid[3] = (t != 1) && (cnt < 3);
      m_last[3]  = (cnt == 2);
      set_data(3, 32'hC300_0000 + cnt);
      cycle(g);
      if (g == 3) cnt++;
      if (g == 0) m_valid[0] = 1'b0;
    end
    m_valid = '0; m_last = '0;
    repeat (2) cycle(g);

    // Randomized traffic with occasional reset.
    repeat (400) begin
      m_valid = N'($urandom);
      m_last  = N'($urandom);
      s_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      cycle(g);
    end
    rst = 1'b0; m_last = '0;

    // Reset while two beats are stored.
    m_valid = '1; s_ready = 1'b0;
    for (int i = 0; i < N; i++) set_data(i, 32'hE000_0000 + i);
    repeat (3) cycle(g);
    rst = 1'b1;
    cycle(g);
    rst = 1'b0; s_ready = 1'b1;
    cycle(g);
    chk("post_rst_grant", 64'(g), 64'd0);
    m_valid = '0;
    repeat (4) cycle(g);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
